ram_fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter that shares one RAM FIFO enqueue port (wren/wrdata/full) among NREQ producers.
- Each producer uses a valid/ready handshake.
- A granted producer may hold the port for a burst of up to MAX_BURST beats, so its data stays contiguous in the FIFO.
- Sits directly in front of the FIFO write side. The integration ties FIFO enable high.

---
 rtl/fifo_arb_pkg.sv | 10 +
 rtl/rr_priority_pick.sv | 27 ++
 rtl/ram_fifo_wr_arbiter.sv | 85 ++++++++
 tb/tb_ram_fifo_wr_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, defaults and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
    localparam int NREQ_DEF      = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or after rr_ptr, searching circularly
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic          found,
    output logic [PW-1:0] pick
);
    logic [N-1:0]  rot;
    logic [PW-1:0] idx;
    logic [PW-1:0] off;
    always_comb begin
        rot = '0;
        idx = '0;
        off = '0;
        for (int i = 0; i < N; i++) begin
            idx    = PW'((int'(rr_ptr) + i) % N);
            rot[i] = req[idx];
        end
        for (int i = N - 1; i >= 0; i--)
            off = rot[i] ? PW'(i) : off;
        found = |rot;
        pick  = PW'((int'(off) + int'(rr_ptr)) % N);
    end
endmodule

// File: rtl/ram_fifo_wr_arbiter.sv
// ram_fifo_wr_arbiter: round-robin, burst-locking arbiter sharing one FIFO enqueue port
module ram_fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [NREQ-1:0]               i_valid,
    input  logic [NREQ*DATA_W-1:0]        i_data,
    output logic [NREQ-1:0]               o_ready,
    output logic                          o_wren,
    output logic [DATA_W-1:0]             o_wrdata,
    input  logic                          i_full,
    output logic [clog2_min1(NREQ)-1:0]   o_grant_id,
    output logic                          o_busy
);
    localparam int IW = clog2_min1(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    arb_state_t    state, state_n;
    logic [IW-1:0] rr_ptr, rr_n, owner, owner_n, pick, sel;
    logic [BW-1:0] beat_cnt, cnt_n;
    logic          found, sel_vld, xfer;

    rr_priority_pick #(.N(NREQ), .PW(IW)) u_pick (
        .req    (i_valid),
        .rr_ptr (rr_ptr),
        .found  (found),
        .pick   (pick)
    );

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        sel        = (state == ARB_LOCK) ? owner : pick;
        sel_vld    = (state == ARB_LOCK) ? i_valid[owner] : found;
        xfer       = !rst && i_en && !i_full && sel_vld;
        o_wren     = xfer;
        o_ready    = xfer ? NREQ'(1) << sel : '0;
        o_wrdata   = xfer ? i_data[int'(sel)*DATA_W +: DATA_W] : '0;
        o_grant_id = rst ? '0 : sel;
        o_busy     = !rst && state == ARB_LOCK;
    end

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        owner_n = owner;
        cnt_n   = beat_cnt;
        if (state == ARB_IDLE) begin
            if (xfer) begin
                owner_n = pick;
                cnt_n   = BW'(1);
                state_n = (MAX_BURST > 1) ? ARB_LOCK : ARB_IDLE;
                rr_n    = (MAX_BURST > 1) ? rr_ptr : wrap_inc(pick);
            end
        end else if (i_en && !i_valid[owner]) begin
            state_n = ARB_IDLE;
            rr_n    = wrap_inc(owner);
        end else if (xfer) begin
            cnt_n   = beat_cnt + 1'b1;
            state_n = (cnt_n == BW'(MAX_BURST)) ? ARB_IDLE : ARB_LOCK;
            rr_n    = (cnt_n == BW'(MAX_BURST)) ? wrap_inc(owner) : rr_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_n;
            owner    <= owner_n;
            beat_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_ram_fifo_wr_arbiter.sv
// tb_ram_fifo_wr_arbiter: scoreboard bench for two arbiter configurations against a behavioural model
module tb_ram_fifo_wr_arbiter;
    typedef struct { bit locked; int owner; int beats; int rr; } mdl_t;
    typedef struct { int id; logic [7:0] d; } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, full_a, wren_a, busy_a;
    logic [3:0]  valid_a, ready_a;
    logic [31:0] data_a;
    logic [7:0]  wrdata_a;
    logic [1:0]  grant_a;
    logic        en_b, full_b, wren_b, busy_b;
    logic [2:0]  valid_b, ready_b;
    logic [23:0] data_b;
    logic [7:0]  wrdata_b;
    logic [1:0]  grant_b;

    int    n_chk = 0;
    int    n_fail = 0;
    mdl_t  ma, mb;
    beat_t qa[$], qb[$];
    int    log_a[$], log_b[$];
    int    rr_exp[20] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0};
    int    b_exp[6]   = '{0,1,2,0,1,2};

    always #5 clk = ~clk;

    ram_fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .MAX_BURST(4)) u_a (
        .clk(clk), .rst(rst), .i_en(en_a), .i_valid(valid_a), .i_data(data_a),
        .o_ready(ready_a), .o_wren(wren_a), .o_wrdata(wrdata_a), .i_full(full_a),
        .o_grant_id(grant_a), .o_busy(busy_a)
    );

    ram_fifo_wr_arbiter #(.NREQ(3), .DATA_W(8), .MAX_BURST(1)) u_b (
        .clk(clk), .rst(rst), .i_en(en_b), .i_valid(valid_b), .i_data(data_b),
        .o_ready(ready_b), .o_wren(wren_b), .o_wrdata(wrdata_b), .i_full(full_b),
        .o_grant_id(grant_b), .o_busy(busy_b)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int mdl_pick(input int rr, input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++)
            if (v[(rr + k) % n]) return (rr + k) % n;
        return -1;
    endfunction

    task automatic mdl_step(inout mdl_t m, input logic [15:0] v, input logic f, input logic e,
                            input int n, input int mbst, output int id);
        int p;
        id = -1;
        p = mdl_pick(m.rr, v, n);
        if (!e) return;
        if (!m.locked) begin
            if (p >= 0 && !f) begin
                id = p;
                if (mbst > 1) begin
                    m.locked = 1; m.owner = p; m.beats = 1;
                end else m.rr = (p + 1) % n;
            end
        end else if (!v[m.owner]) begin
            m.locked = 0; m.rr = (m.owner + 1) % n;
        end else if (!f) begin
            id = m.owner;
            m.beats++;
            if (m.beats == mbst) begin
                m.locked = 0; m.rr = (m.owner + 1) % n;
            end
        end
    endtask

    always @(negedge clk) begin
        int id;
        #1;
        if (rst) ma = '{0, 0, 0, 0};
        else begin
            check("a_busy", 32'(busy_a), 32'(ma.locked));
            if (ma.locked) check("a_grant_lock", 32'(grant_a), ma.owner);
            mdl_step(ma, 16'(valid_a), full_a, en_a, 4, 4, id);
            if (id >= 0) qa.push_back('{id, data_a[id*8 +: 8]});
        end
    end

    always @(negedge clk) begin
        int id;
        #1;
        if (rst) mb = '{0, 0, 0, 0};
        else begin
            check("b_busy", 32'(busy_b), 32'(mb.locked));
            mdl_step(mb, 16'(valid_b), full_b, en_b, 3, 1, id);
            if (id >= 0) qb.push_back('{id, data_b[id*8 +: 8]});
        end
    end

    always @(negedge clk) begin
        beat_t e;
        #2;
        check("a_wren", 32'(wren_a), 32'(qa.size() != 0));
        if (wren_a) log_a.push_back(int'(grant_a));
        if (wren_a && qa.size() != 0) begin
            e = qa.pop_front();
            check("a_grant", 32'(grant_a), e.id);
            check("a_data", 32'(wrdata_a), 32'(e.d));
            check("a_ready", 32'(ready_a), 32'(1) << e.id);
        end else begin
            check("a_ready_idle", 32'(ready_a), 0);
            check("a_data_idle", 32'(wrdata_a), 0);
        end
        qa.delete();
    end

    always @(negedge clk) begin
        beat_t e;
        #2;
        check("b_wren", 32'(wren_b), 32'(qb.size() != 0));
        if (wren_b) log_b.push_back(int'(grant_b));
        if (wren_b && qb.size() != 0) begin
            e = qb.pop_front();
            check("b_grant", 32'(grant_b), e.id);
            check("b_data", 32'(wrdata_b), 32'(e.d));
            check("b_ready", 32'(ready_b), 32'(1) << e.id);
        end else begin
            check("b_ready_idle", 32'(ready_b), 0);
            check("b_data_idle", 32'(wrdata_b), 0);
        end
        qb.delete();
    end

    task automatic drive(input logic r, input logic [3:0] va, input logic fa, input logic ea,
                         input logic [2:0] vb, input logic fb, input logic eb);
        @(negedge clk);
        rst = r;
        valid_a = va; full_a = fa; en_a = ea; data_a = $urandom;
        valid_b = vb; full_b = fb; en_b = eb; data_b = 24'($urandom);
        #3;
    endtask

    task automatic cyc_a(input logic [3:0] v, input logic f, input logic e);
        drive(1'b0, v, f, e, 3'b000, 1'b0, 1'b1);
    endtask

    task automatic st(input string n, input logic w, input logic b);
        check({n, "_wren"}, 32'(wren_a), 32'(w));
        check({n, "_busy"}, 32'(busy_a), 32'(b));
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b1; valid_a = 4'hF; full_a = 1'b0; data_a = '0;
        en_b = 1'b1; valid_b = 3'b111; full_b = 1'b0; data_b = '0;
        repeat (2) drive(1'b1, 4'hF, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1);
        st("rst", 1'b0, 1'b0);
        check("rst_ready", 32'(ready_a), 0);
        check("rst_data", 32'(wrdata_a), 0);
        check("rst_grant", 32'(grant_a), 0);
        log_a.delete();
        repeat (20) cyc_a(4'hF, 1'b0, 1'b1);
        check("rr_count", log_a.size(), 20);
        for (int i = 0; i < 20 && i < log_a.size(); i++)
            check($sformatf("rr_order%0d", i), log_a[i], rr_exp[i]);
        repeat (2) cyc_a(4'b0100, 1'b0, 1'b1);
        st("mid_burst", 1'b1, 1'b1);
        check("mid_burst_grant", 32'(grant_a), 2);
        drive(1'b1, 4'hF, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
        st("mid_rst", 1'b0, 1'b0);
        check("mid_rst_ready", 32'(ready_a), 0);
        cyc_a(4'hF, 1'b0, 1'b1);
        st("after_rst", 1'b1, 1'b0);
        check("after_rst_grant", 32'(grant_a), 0);
        log_a.delete();
        cyc_a(4'b0010, 1'b0, 1'b1);
        st("bp_rel", 1'b0, 1'b1);
        cyc_a(4'b0010, 1'b0, 1'b1);
        st("bp_b1", 1'b1, 1'b0);
        check("bp_b1_grant", 32'(grant_a), 1);
        repeat (3) begin
            cyc_a(4'b0010, 1'b1, 1'b1);
            st("bp_stall", 1'b0, 1'b1);
            check("bp_stall_ready", 32'(ready_a), 0);
        end
        repeat (3) begin
            cyc_a(4'b0010, 1'b0, 1'b1);
            st("bp_run", 1'b1, 1'b1);
        end
        check("bp_beats", log_a.size(), 4);
        foreach (log_a[i]) check("bp_owner", log_a[i], 1);
        cyc_a(4'b0000, 1'b0, 1'b1);
        st("bp_done", 1'b0, 1'b0);
        cyc_a(4'b0010, 1'b0, 1'b1);
        st("er_b1", 1'b1, 1'b0);
        cyc_a(4'b1010, 1'b0, 1'b1);
        st("er_b2", 1'b1, 1'b1);
        check("er_ready", 32'(ready_a), 32'h2);
        cyc_a(4'b1000, 1'b0, 1'b1);
        st("er_bubble", 1'b0, 1'b1);
        cyc_a(4'b1000, 1'b0, 1'b1);
        st("er_next", 1'b1, 1'b0);
        check("er_grant", 32'(grant_a), 3);
        cyc_a(4'b0000, 1'b0, 1'b1);
        repeat (2) begin
            cyc_a(4'b0101, 1'b1, 1'b1);
            st("full_idle", 1'b0, 1'b0);
            check("full_idle_ready", 32'(ready_a), 0);
        end
        cyc_a(4'b0101, 1'b0, 1'b1);
        st("full_drop", 1'b1, 1'b0);
        check("full_drop_grant", 32'(grant_a), 0);
        cyc_a(4'b0000, 1'b0, 1'b1);
        cyc_a(4'hF, 1'b0, 1'b0);
        st("en_low", 1'b0, 1'b0);
        cyc_a(4'b0000, 1'b0, 1'b1);
        log_b.delete();
        repeat (6) begin
            drive(1'b0, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1);
            check("b_busy_low", 32'(busy_b), 0);
        end
        check("b_count", log_b.size(), 6);
        for (int i = 0; i < 6 && i < log_b.size(); i++)
            check($sformatf("b_order%0d", i), log_b[i], b_exp[i]);
        repeat (800)
            drive($urandom_range(0, 199) == 0, 4'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) != 0, 3'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) != 0);
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
